// File: rtl/gen_gamma_decoder.sv
// Two-stage exp-Golomb order-K decoder: one left-aligned codeword in per cycle,
// {err, value} out two edges later.

module gen_gamma_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) q_o <= '0;
        else         q_o <= d_i;
    end
endmodule

module gen_gamma_sub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] d_o
);
    assign d_o = a_i - b_i;
endmodule

module gen_gamma_decoder #(
    parameter int WIDTH = 8,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [WIDTH-1:0] inp_data,
    output logic [WIDTH:0]   out_data
);
    localparam int ZW = $clog2(WIDTH + 1);
    localparam int LW = $clog2(2 * WIDTH + K + 2);
    localparam logic [WIDTH-1:0] ONE_K = WIDTH'(1) << K;

    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    logic [ZW-1:0]    zeros;
    logic [LW-1:0]    len;
    logic [LW-1:0]    shift;
    logic             err;
    logic [WIDTH-1:0] field;
    logic [WIDTH-1:0] value;
    logic [WIDTH:0]   out_d;

    // vld_q keeps the output at 0 for the first edge after reset instead of
    // decoding the cleared stage-1 word as an error.
    gen_gamma_reg #(.W(WIDTH + 1)) u_stage1 (
        .clk_i  (clk),
        .rst_ni (res_n),
        .d_i    ({1'b1, inp_data}),
        .q_o    ({vld_q, data_q})
    );

    always_comb begin
        zeros = ZW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_q[i]) zeros = ZW'(WIDTH - 1 - i);
        end
    end

    assign len   = (LW'(zeros) << 1) + LW'(K + 1);
    assign err   = (zeros == ZW'(WIDTH)) || (len > LW'(WIDTH));
    assign shift = LW'(WIDTH) - len;
    // Right-aligning the top L bits yields M; the leading zeros above it are harmless.
    assign field = data_q >> shift;

    gen_gamma_sub #(.W(WIDTH)) u_sub (
        .a_i (field),
        .b_i (ONE_K),
        .d_o (value)
    );

    always_comb begin
        out_d = '0;
        if (vld_q) begin
            if (err) out_d = {1'b1, {WIDTH{1'b0}}};
            else     out_d = {1'b0, value};
        end
    end

    gen_gamma_reg #(.W(WIDTH + 1)) u_out (
        .clk_i  (clk),
        .rst_ni (res_n),
        .d_i    (out_d),
        .q_o    (out_data)
    );
endmodule

// File: tb/tb_gen_gamma_decoder.sv
// Directed bench for gen_gamma_decoder: K=0 and K=1 instances, single words,
// streaming and asynchronous reset.

module tb_gen_gamma_decoder;
    logic       clk;
    logic       res_n;
    logic [7:0] inp_k0, inp_k1;
    logic [8:0] out_k0, out_k1;
    int         n_vec;
    int         n_err;

    gen_gamma_decoder #(.WIDTH(8), .K(0)) u_k0 (
        .clk(clk), .res_n(res_n), .inp_data(inp_k0), .out_data(out_k0)
    );
    gen_gamma_decoder #(.WIDTH(8), .K(1)) u_k1 (
        .clk(clk), .res_n(res_n), .inp_data(inp_k1), .out_data(out_k1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        res_n  = 1'b0;
        inp_k0 = 8'h80;
        inp_k1 = 8'h80;
        #12;
        n_vec++;
        if (out_k0 !== 9'h000) begin
            n_err++;
            $display("FAIL reset_k0: got %h want %h", out_k0, 9'h000);
        end
        n_vec++;
        if (out_k1 !== 9'h000) begin
            n_err++;
            $display("FAIL reset_k1: got %h want %h", out_k1, 9'h000);
        end
        @(posedge clk); #1;
        res_n = 1'b1;
    endtask

    task automatic test_basic_k0();
        logic [7:0] vin [8];
        logic [8:0] vexp [8];
        vin = '{8'h80, 8'h40, 8'h60, 8'h1E, 8'h1F, 8'h00, 8'h08, 8'h01};
        vexp = '{9'h000, 9'h001, 9'h002, 9'h00E, 9'h00E, 9'h100, 9'h100, 9'h100};
        for (int i = 0; i < 8; i++) begin
            inp_k0 = vin[i];
            @(posedge clk); @(posedge clk); #1;
            n_vec++;
            if (out_k0 !== vexp[i]) begin
                n_err++;
                $display("FAIL basic_k0[%0d] in=%h: got %h want %h", i, vin[i], out_k0, vexp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vin [4];
        logic [8:0] vexp [4];
        vin  = '{8'h80, 8'h40, 8'h60, 8'h1E};
        vexp = '{9'h000, 9'h001, 9'h002, 9'h00E};
        inp_k0 = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            inp_k0 = vin[i];
            @(posedge clk); #1;
            // one edge after applying a word, the previous result must still show
            if (i == 0) begin
                n_vec++;
                if (out_k0 !== 9'h100) begin
                    n_err++;
                    $display("FAIL stream_latency: got %h want %h", out_k0, 9'h100);
                end
            end else begin
                n_vec++;
                if (out_k0 !== vexp[i-1]) begin
                    n_err++;
                    $display("FAIL stream[%0d]: got %h want %h", i - 1, out_k0, vexp[i-1]);
                end
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_k0 !== vexp[3]) begin
            n_err++;
            $display("FAIL stream[3]: got %h want %h", out_k0, vexp[3]);
        end
    endtask

    task automatic test_async_reset();
        inp_k0 = 8'h40;
        @(posedge clk); @(posedge clk); #3;
        res_n = 1'b0;
        #1;
        n_vec++;
        if (out_k0 !== 9'h000) begin
            n_err++;
            $display("FAIL async_clear: got %h want %h", out_k0, 9'h000);
        end
        @(posedge clk); #3;
        res_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (out_k0 !== 9'h000) begin
            n_err++;
            $display("FAIL post_reset_edge1: got %h want %h", out_k0, 9'h000);
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_k0 !== 9'h001) begin
            n_err++;
            $display("FAIL post_reset_edge2: got %h want %h", out_k0, 9'h001);
        end
    endtask

    task automatic test_order_k1();
        logic [7:0] vin [6];
        logic [8:0] vexp [6];
        vin  = '{8'h80, 8'hC0, 8'h40, 8'h78, 8'h10, 8'h08};
        vexp = '{9'h000, 9'h001, 9'h002, 9'h005, 9'h00E, 9'h100};
        for (int i = 0; i < 6; i++) begin
            inp_k1 = vin[i];
            @(posedge clk); @(posedge clk); #1;
            n_vec++;
            if (out_k1 !== vexp[i]) begin
                n_err++;
                $display("FAIL order_k1[%0d] in=%h: got %h want %h", i, vin[i], out_k1, vexp[i]);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic_k0();
        test_back_to_back();
        test_async_reset();
        test_order_k1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
